// File: rtl/measure_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : measure_write_scheduler
//  Description : Sequences note capture into the 20-measure transcription RAM.
//                Owns the eighth-note timebase and metronome, sweeps the RAM
//                to zero before every take, assembles each 48-bit measure
//                word (8 x 6-bit eighth lanes) and issues one port-A write
//                per captured eighth.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_in        : system clock (sole clock)
//    rst_in        : synchronous active-high reset
//    toggle_in     : record enable level
//    bpm_in        : tempo select (10=120, 01=80, 00/11=60 bpm)
//    note_in       : detected note code (0 = rest)
//    wr_en_out     : RAM port A write strobe
//    wr_addr_out   : RAM port A measure address 0..19
//    wr_data_out   : RAM port A data, lane k at bits [6k+5:6k]
//    slot_out      : eighth slots captured so far this take
//    recording_out : high in RECORD
//    clearing_out  : high in CLEAR
//    done_out      : high in DONE
//    metronome_out : click pulse at the start of each eighth
// ============================================================================
module measure_write_scheduler #(
  parameter int SLOTS     = 8,
  parameter int MEASURES  = 20,
  parameter int NOTE_W    = 6,
  parameter int TICKS_120 = 18562500,
  parameter int TICKS_80  = 27843750,
  parameter int TICKS_60  = 37125000,
  parameter int CLICK     = 200000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      toggle_in,
  input  logic [1:0]                bpm_in,
  input  logic [NOTE_W-1:0]         note_in,
  output logic                      wr_en_out,
  output logic [4:0]                wr_addr_out,
  output logic [SLOTS*NOTE_W-1:0]   wr_data_out,
  output logic [7:0]                slot_out,
  output logic                      recording_out,
  output logic                      clearing_out,
  output logic                      done_out,
  output logic                      metronome_out
);

  localparam int c_tick_w = 26;
  localparam int c_data_w = SLOTS * NOTE_W;
  localparam logic [c_tick_w-1:0] c_tick_one    = c_tick_w'(1);
  localparam logic [c_tick_w-1:0] c_click       = c_tick_w'(CLICK);
  localparam logic [c_tick_w-1:0] c_period_120  = c_tick_w'(TICKS_120);
  localparam logic [c_tick_w-1:0] c_period_80   = c_tick_w'(TICKS_80);
  localparam logic [c_tick_w-1:0] c_period_60   = c_tick_w'(TICKS_60);
  localparam logic [4:0]          c_last_addr   = 5'(MEASURES - 1);
  localparam logic [7:0]          c_total_slots = 8'(SLOTS * MEASURES);

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_RECORD = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [4:0]            r_sweep_addr;
  logic [c_tick_w-1:0]   r_tick;
  logic [c_tick_w-1:0]   r_period;
  logic [7:0]            r_slot;
  logic [c_data_w-1:0]   r_buffer;
  logic                  r_wr_en;
  logic [4:0]            r_wr_addr;
  logic [c_data_w-1:0]   r_wr_data;

  logic                  w_sweep_last;
  logic                  w_tick_wrap;
  logic                  w_capture;
  logic                  w_last_write;
  logic [c_tick_w-1:0]   w_period_sel;
  logic [c_data_w-1:0]   w_buf_next;

  assign w_sweep_last = (r_sweep_addr == c_last_addr);
  assign w_tick_wrap  = (r_tick == (r_period - c_tick_one));
  // Dropping toggle_in on the capture cycle discards that eighth entirely.
  assign w_capture    = (r_state == S_RECORD) && toggle_in && w_tick_wrap;
  // The final write is visible while still in RECORD; DONE follows it.
  assign w_last_write = r_wr_en && (r_slot == c_total_slots);

  always_comb begin
    case (bpm_in)
      2'b10:   w_period_sel = c_period_120;
      2'b01:   w_period_sel = c_period_80;
      default: w_period_sel = c_period_60;
    endcase
  end

  // Measure word with the current note merged into its lane.
  always_comb begin
    w_buf_next = r_buffer;
    w_buf_next[r_slot[2:0]*NOTE_W +: NOTE_W] = note_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_CLEAR;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR:  if (w_sweep_last) w_state_next = toggle_in ? S_RECORD : S_IDLE;
      S_IDLE:   if (toggle_in) w_state_next = S_CLEAR;
      S_RECORD: begin
        if (!toggle_in)        w_state_next = S_IDLE;
        else if (w_last_write) w_state_next = S_DONE;
      end
      S_DONE:   if (!toggle_in) w_state_next = S_IDLE;
      default:  w_state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sweep_addr <= '0;
      r_tick       <= '0;
      r_period     <= '0;
      r_slot       <= '0;
      r_buffer     <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_sweep_addr <= w_sweep_last ? 5'd0 : r_sweep_addr + 5'd1;
          if (w_sweep_last && toggle_in) begin
            // Tempo is fixed for the whole take from this point.
            r_period <= w_period_sel;
            r_tick   <= '0;
            r_slot   <= '0;
            r_buffer <= '0;
          end
        end
        S_IDLE: begin
          if (toggle_in) begin
            r_sweep_addr <= '0;
            r_slot       <= '0;
          end
        end
        S_RECORD: begin
          r_tick <= w_tick_wrap ? '0 : r_tick + c_tick_one;
          if (w_capture) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_slot[7:3];
            r_wr_data <= w_buf_next;
            r_slot    <= r_slot + 8'd1;
            // A completed measure leaves a blank buffer for the next one.
            r_buffer  <= (r_slot[2:0] == 3'd7) ? '0 : w_buf_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Sweep writes come straight from the state; reset masks the strobe.
  assign wr_en_out     = !rst_in && ((r_state == S_CLEAR) || r_wr_en);
  assign wr_addr_out   = (r_state == S_CLEAR) ? r_sweep_addr :
                         (r_wr_en ? r_wr_addr : 5'd0);
  assign wr_data_out   = ((r_state != S_CLEAR) && r_wr_en) ? r_wr_data : '0;
  assign slot_out      = r_slot;
  assign recording_out = (r_state == S_RECORD);
  assign clearing_out  = (r_state == S_CLEAR);
  assign done_out      = (r_state == S_DONE);
  assign metronome_out = (r_state == S_RECORD) && (r_tick < c_click);

endmodule
`default_nettype wire
